// File: rtl/spi_s_pkg.sv
// Shared types and elaboration helpers for the SPI slave register bridge.
package spi_s_pkg;

   typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

   // Data is sampled on SCLK rising when CPOL and CPHA agree, else on falling.
   function automatic logic sample_rising(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

   function automatic int unsigned hdr_len(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall pulses
// taken from the last two stages.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic PIN,
   output logic RISE,
   output logic FALL
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], PIN};
      end
   end

   assign RISE = sync_q[STAGES-2] & ~sync_q[STAGES-1];
   assign FALL = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_s_regbridge.sv
// SPI slave bridging {RW, ADDR} + data-word frames onto a single-port register bus,
// with auto-incrementing bursts and read prefetch. All logic runs on CLK.
module spi_s_regbridge
   import spi_s_pkg::*;
#(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CPOL        = 0,
   parameter int unsigned CPHA        = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CSN,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   output logic              WEN,
   output logic              REN,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] DIN,
   input  logic [DATA_W-1:0] DOUT,
   output logic              ERR
);

   localparam int unsigned HdrLen     = hdr_len(ADDR_W);
   localparam int unsigned MaxLen     = (HdrLen > DATA_W) ? HdrLen : DATA_W;
   localparam int unsigned CntW       = $clog2(MaxLen);
   localparam logic        SampleRise = sample_rising(CPOL != 0, CPHA != 0);
   localparam logic [CntW-1:0] HdrLast  = CntW'(HdrLen - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

   logic sclk_rise, sclk_fall, csn_rise, csn_fall;
   logic sample_edge, shift_edge;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [MaxLen-2:0]   rx_q, rx_d;
   logic [MaxLen-1:0]   rx_shift;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [DATA_W-1:0]   txbuf_q, txbuf_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                oe_q, oe_d;
   logic                wen_q, wen_d;
   logic                ren_q, ren_d;
   logic                err_q, err_d;
   logic                cap_q;

   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sclk_sync (
      .CLK  (CLK),
      .RST  (RST),
      .PIN  (SCLK),
      .RISE (sclk_rise),
      .FALL (sclk_fall)
   );

   // Reset low so a frame already in progress at reset release produces no fall.
   spi_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_csn_sync (
      .CLK  (CLK),
      .RST  (RST),
      .PIN  (CSN),
      .RISE (csn_rise),
      .FALL (csn_fall)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      end
   end

   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sample_edge = SampleRise ? sclk_rise : sclk_fall;
   assign shift_edge  = SampleRise ? sclk_fall : sclk_rise;
   assign rx_shift    = {rx_q, mosi_s};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      din_d   = din_q;
      txbuf_d = txbuf_q;
      tx_d    = tx_q;
      oe_d    = oe_q;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      err_d   = 1'b0;

      if (wen_q) addr_d = addr_q + 1'b1;
      if (cap_q) txbuf_d = DOUT;

      unique case (state_q)
         StIdle: begin
            if (csn_fall) begin
               state_d = StHdr;
               cnt_d   = '0;
               oe_d    = 1'b1;
               tx_d    = '0;
            end
         end
         StHdr, StData: begin
            // CSN rise beats a coincident sample edge; that word is then partial.
            if (csn_rise) begin
               state_d = StIdle;
               cnt_d   = '0;
               oe_d    = 1'b0;
               tx_d    = '0;
               err_d   = (cnt_q != '0);
            end else if (sample_edge) begin
               rx_d = rx_shift[MaxLen-2:0];
               if (state_q == StHdr) begin
                  if (cnt_q == HdrLast) begin
                     cnt_d   = '0;
                     state_d = StData;
                     rw_d    = rx_shift[ADDR_W];
                     addr_d  = rx_shift[ADDR_W-1:0];
                     ren_d   = ~rx_shift[ADDR_W];
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (cnt_q == DataLast) begin
                  cnt_d = '0;
                  if (rw_q) begin
                     din_d = rx_shift[DATA_W-1:0];
                     wen_d = 1'b1;
                  end else begin
                     addr_d = addr_q + 1'b1;
                     ren_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (shift_edge && state_q == StData && !rw_q) begin
               // First shift opportunity of a word loads the prefetched data.
               tx_d = (cnt_q == '0) ? txbuf_q : {tx_q[DATA_W-2:0], 1'b0};
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rx_q    <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         txbuf_q <= '0;
         tx_q    <= '0;
         oe_q    <= 1'b0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
         err_q   <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         txbuf_q <= txbuf_d;
         tx_q    <= tx_d;
         oe_q    <= oe_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
         err_q   <= err_d;
         cap_q   <= ren_q;
      end
   end

   assign MISO    = tx_q[DATA_W-1];
   assign MISO_OE = oe_q;
   assign WEN     = wen_q;
   assign REN     = ren_q;
   assign ADDR    = addr_q;
   assign DIN     = din_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_spi_s_regbridge.sv
// Directed bench for spi_s_regbridge: one instance per SPI mode, a bus model
// answering reads from a fixed table, and logs of WEN/REN/ERR activity.
module tb_spi_s_regbridge;

   localparam int HALF = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mosi = 1'b0;
   logic [3:0] csn_v = 4'hF;
   logic [3:0] sclk_v = 4'b1100;
   logic [3:0] miso_v, oe_v, wen_v, ren_v, err_v;
   logic [6:0] addr_a [4];
   logic [7:0] din_a  [4];
   logic [7:0] dout_a [4];

   logic [6:0] wen_al [4][16];
   logic [7:0] wen_dl [4][16];
   logic [6:0] ren_al [4][16];
   int wen_n [4];
   int ren_n [4];
   int err_n [4];

   int total = 0;
   int bad = 0;

   logic [7:0] f_tx [8];
   logic [7:0] f_rx [8];
   logic       f_oe;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_s_regbridge #(
         .ADDR_W      (7),
         .DATA_W      (8),
         .CPOL        ((g / 2) % 2),
         .CPHA        (g % 2),
         .SYNC_STAGES (2)
      ) u_dut (
         .CLK     (clk),
         .RST     (rst),
         .CSN     (csn_v[g]),
         .SCLK    (sclk_v[g]),
         .MOSI    (mosi),
         .MISO    (miso_v[g]),
         .MISO_OE (oe_v[g]),
         .WEN     (wen_v[g]),
         .REN     (ren_v[g]),
         .ADDR    (addr_a[g]),
         .DIN     (din_a[g]),
         .DOUT    (dout_a[g]),
         .ERR     (err_v[g])
      );
   end

   function automatic logic [7:0] mem_val(input logic [6:0] a);
      case (a)
         7'h12:   return 8'hA5;
         7'h40:   return 8'hB4;
         7'h41:   return 8'h2D;
         default: return {1'b0, a} ^ 8'h5A;
      endcase
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wen_v[i]) begin
            wen_al[i][wen_n[i] % 16] <= addr_a[i];
            wen_dl[i][wen_n[i] % 16] <= din_a[i];
            wen_n[i] <= wen_n[i] + 1;
         end
         if (ren_v[i]) begin
            ren_al[i][ren_n[i] % 16] <= addr_a[i];
            ren_n[i] <= ren_n[i] + 1;
            dout_a[i] <= mem_val(addr_a[i]);
         end
         if (err_v[i]) err_n[i] <= err_n[i] + 1;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (m % 2 == 0) begin
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso_v[m];
            sclk_v[m] = ~sclk_v[m];
            wait_clk(HALF);
            sclk_v[m] = ~sclk_v[m];
         end else begin
            sclk_v[m] = ~sclk_v[m];
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso_v[m];
            sclk_v[m] = ~sclk_v[m];
            wait_clk(HALF);
         end
      end
   endtask

   task automatic frame(input int m, input int nbytes, input int last_bits);
      logic [7:0] r;
      csn_v[m] = 1'b0;
      wait_clk(HALF);
      for (int b = 0; b < nbytes; b++) begin
         spi_bits(m, f_tx[b], (b == nbytes - 1) ? last_bits : 8, r);
         f_rx[b] = r;
         if (b == 0) f_oe = oe_v[m];
      end
      wait_clk(HALF);
      csn_v[m] = 1'b1;
      wait_clk(2 * HALF);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(5);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({miso_v[i], oe_v[i], wen_v[i], ren_v[i], err_v[i], addr_a[i], din_a[i]} !== 20'h0) begin
            bad++;
            $display("FAIL reset_state mode%0d: got miso/oe/wen/ren/err=%b%b%b%b%b addr=%h din=%h, want all 0",
                     i, miso_v[i], oe_v[i], wen_v[i], ren_v[i], err_v[i], addr_a[i], din_a[i]);
         end
      end
   endtask

   task automatic test_write;
      int wb = wen_n[0];
      int eb = err_n[0];
      f_tx[0] = 8'h85;
      f_tx[1] = 8'h3C;
      frame(0, 2, 8);
      total++;
      if (wen_n[0] - wb !== 1) begin
         bad++;
         $display("FAIL write_wen_count: got %0d want 1", wen_n[0] - wb);
      end
      total++;
      if ({wen_al[0][wb % 16], wen_dl[0][wb % 16]} !== {7'h05, 8'h3C}) begin
         bad++;
         $display("FAIL write_addr_data: got addr=%h din=%h want addr=05 din=3c",
                  wen_al[0][wb % 16], wen_dl[0][wb % 16]);
      end
      total++;
      if (err_n[0] - eb !== 0) begin
         bad++;
         $display("FAIL write_err: got %0d pulses want 0", err_n[0] - eb);
      end
      total++;
      if ({f_oe, oe_v[0]} !== 2'b10) begin
         bad++;
         $display("FAIL write_miso_oe: got selected=%b deselected=%b want 1/0", f_oe, oe_v[0]);
      end
   endtask

   task automatic test_read;
      int rb = ren_n[0];
      f_tx[0] = 8'h12;
      f_tx[1] = 8'h00;
      frame(0, 2, 8);
      total++;
      if (f_rx[0] !== 8'h00) begin
         bad++;
         $display("FAIL read_hdr_miso: got %h want 00", f_rx[0]);
      end
      total++;
      if (f_rx[1] !== 8'hA5) begin
         bad++;
         $display("FAIL read_data: got %h want a5", f_rx[1]);
      end
      total++;
      if ({ren_n[0] - rb, ren_al[0][rb % 16], ren_al[0][(rb + 1) % 16]} !== {32'd2, 7'h12, 7'h13}) begin
         bad++;
         $display("FAIL read_ren: got count=%0d addrs=%h,%h want 2 at 12,13",
                  ren_n[0] - rb, ren_al[0][rb % 16], ren_al[0][(rb + 1) % 16]);
      end
   endtask

   task automatic test_burst_write;
      int wb = wen_n[0];
      f_tx[0] = 8'hFE;
      f_tx[1] = 8'h11;
      f_tx[2] = 8'h22;
      f_tx[3] = 8'h33;
      frame(0, 4, 8);
      total++;
      if (wen_n[0] - wb !== 3) begin
         bad++;
         $display("FAIL burst_wen_count: got %0d want 3", wen_n[0] - wb);
      end
      total++;
      if ({wen_al[0][wb % 16], wen_dl[0][wb % 16], wen_al[0][(wb + 1) % 16], wen_dl[0][(wb + 1) % 16],
           wen_al[0][(wb + 2) % 16], wen_dl[0][(wb + 2) % 16]} !== {7'h7E, 8'h11, 7'h7F, 8'h22, 7'h00, 8'h33}) begin
         bad++;
         $display("FAIL burst_wrap: got %h=%h %h=%h %h=%h want 7e=11 7f=22 00=33",
                  wen_al[0][wb % 16], wen_dl[0][wb % 16], wen_al[0][(wb + 1) % 16],
                  wen_dl[0][(wb + 1) % 16], wen_al[0][(wb + 2) % 16], wen_dl[0][(wb + 2) % 16]);
      end
   endtask

   task automatic test_modes;
      for (int m = 1; m < 4; m++) begin
         int rb = ren_n[m];
         f_tx[0] = 8'h40;
         f_tx[1] = 8'h00;
         f_tx[2] = 8'h00;
         frame(m, 3, 8);
         total++;
         if ({f_rx[0], f_rx[1], f_rx[2]} !== {8'h00, 8'hB4, 8'h2D}) begin
            bad++;
            $display("FAIL mode%0d_read_data: got %h %h %h want 00 b4 2d", m, f_rx[0], f_rx[1], f_rx[2]);
         end
         total++;
         if ({ren_n[m] - rb, ren_al[m][rb % 16], ren_al[m][(rb + 1) % 16], ren_al[m][(rb + 2) % 16]}
             !== {32'd3, 7'h40, 7'h41, 7'h42}) begin
            bad++;
            $display("FAIL mode%0d_ren: got count=%0d addrs=%h,%h,%h want 3 at 40,41,42", m,
                     ren_n[m] - rb, ren_al[m][rb % 16], ren_al[m][(rb + 1) % 16], ren_al[m][(rb + 2) % 16]);
         end
      end
   endtask

   task automatic test_csn_abort;
      int wb = wen_n[0];
      int eb = err_n[0];
      f_tx[0] = 8'h85;
      f_tx[1] = 8'hF0;
      frame(0, 2, 5);
      total++;
      if ({err_n[0] - eb, wen_n[0] - wb} !== {32'd1, 32'd0}) begin
         bad++;
         $display("FAIL abort_err_wen: got err=%0d wen=%0d want err=1 wen=0", err_n[0] - eb, wen_n[0] - wb);
      end
      wb = wen_n[0];
      eb = err_n[0];
      f_tx[0] = 8'h83;
      f_tx[1] = 8'h5E;
      frame(0, 2, 8);
      total++;
      if ({wen_n[0] - wb, err_n[0] - eb, wen_al[0][wb % 16], wen_dl[0][wb % 16]}
          !== {32'd1, 32'd0, 7'h03, 8'h5E}) begin
         bad++;
         $display("FAIL abort_recover: got wen=%0d err=%0d addr=%h din=%h want 1 0 03 5e",
                  wen_n[0] - wb, err_n[0] - eb, wen_al[0][wb % 16], wen_dl[0][wb % 16]);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] r;
      int wb = wen_n[0];
      int eb = err_n[0];
      csn_v[0] = 1'b0;
      wait_clk(HALF);
      spi_bits(0, 8'h12, 8, r);
      spi_bits(0, 8'h00, 3, r);
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      total++;
      if ({miso_v[0], oe_v[0], wen_v[0], ren_v[0], err_v[0], addr_a[0], din_a[0]} !== 20'h0) begin
         bad++;
         $display("FAIL reset_mid_state: got miso/oe/wen/ren/err=%b%b%b%b%b addr=%h din=%h want all 0",
                  miso_v[0], oe_v[0], wen_v[0], ren_v[0], err_v[0], addr_a[0], din_a[0]);
      end
      spi_bits(0, 8'h00, 5, r);
      wait_clk(HALF);
      csn_v[0] = 1'b1;
      wait_clk(2 * HALF);
      total++;
      if ({err_n[0] - eb, wen_n[0] - wb, oe_v[0]} !== {32'd0, 32'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_ignored: got err=%0d wen=%0d oe=%b want 0 0 0",
                  err_n[0] - eb, wen_n[0] - wb, oe_v[0]);
      end
      f_tx[0] = 8'h81;
      f_tx[1] = 8'h77;
      frame(0, 2, 8);
      total++;
      if ({wen_n[0] - wb, wen_al[0][wb % 16], wen_dl[0][wb % 16]} !== {32'd1, 7'h01, 8'h77}) begin
         bad++;
         $display("FAIL reset_mid_next: got wen=%0d addr=%h din=%h want 1 01 77",
                  wen_n[0] - wb, wen_al[0][wb % 16], wen_dl[0][wb % 16]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_burst_write();
      test_modes();
      test_csn_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
